// File: rtl/iic_slave_regs_if.sv
// I2C pad-side signal bundle for iic_slave_regs.
//   scl_i  : SCL from pad (asynchronous to clk)
//   sda_i  : SDA from pad (asynchronous to clk)
//   sda_oe : 1 = pull SDA low, 0 = release (open-drain control)
// The master modport belongs to whatever models or drives the bus.
// The slave modport is used by the target.
interface iic_slave_regs_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/iic_slave_regs.sv
// I2C target with an 8 x 8-bit register file.
// It uses a 7-bit address and runs at standard-mode speed.
// The first data byte after the address sets the register pointer.
// Each following data byte is written at the pointer, and the pointer then
// auto-increments, wrapping from 7 to 0.
// A read transaction returns the register at the pointer, then pointer+1, and so on.
// Ports:
//   clk       system clock; must run at >= 8x the SCL frequency
//   rst       asynchronous, active-high reset
//   bus       scl_i/sda_i from the pads, sda_oe open-drain pull-down control
//   loc_addr  local read-port register index
//   loc_data  register file[loc_addr], combinational
//   busy      high from address match until STOP/NACK/mismatch
//   wr_pulse  one-clk strobe when a register is written over I2C
//   wr_index  index written, valid with wr_pulse
module iic_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter logic [7:0] REG_RST    = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  iic_slave_regs_if.slave     bus,
  input  logic [2:0]          loc_addr,
  output logic [7:0]          loc_data,
  output logic                busy,
  output logic                wr_pulse,
  output logic [2:0]          wr_index
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_ADDR, S_PTR, S_ACK_PTR,
    S_WDATA, S_ACK_W, S_RDATA, S_RACK, S_WAIT_STOP
  } state_t;

  // Pad synchronizers (2 flops) plus one delay flop for edge detection.
  // They reset to 1, the idle bus level, so releasing reset never fakes an edge.
  logic scl_m_q, scl_s_q, scl_d_q;
  logic sda_m_q, sda_s_q, sda_d_q;

  state_t      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic [2:0]  wr_index_q, wr_index_d;
  logic [7:0]  regs_q [8];

  logic        reg_we;
  logic [7:0]  shift_in;
  logic [7:0]  rd_byte;
  logic        scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_s_q & ~scl_d_q;
  assign scl_fall  = ~scl_s_q &  scl_d_q;
  assign start_det =  scl_s_q &  scl_d_q &  sda_d_q & ~sda_s_q;
  assign stop_det  =  scl_s_q &  scl_d_q & ~sda_d_q &  sda_s_q;

  assign shift_in = {shift_q[6:0], sda_s_q};
  assign rd_byte  = regs_q[ptr_q];

  assign loc_data   = regs_q[loc_addr];
  assign busy       = busy_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_index   = wr_index_q;
  assign bus.sda_oe = sda_oe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_d_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_d_q <= 1'b1;
    end else begin
      scl_m_q <= bus.scl_i;
      scl_s_q <= scl_m_q;
      scl_d_q <= scl_s_q;
      sda_m_q <= bus.sda_i;
      sda_s_q <= sda_m_q;
      sda_d_q <= sda_s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_index_q <= wr_index_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= REG_RST;
    end else if (reg_we) begin
      regs_q[ptr_q] <= shift_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_index_d = wr_index_q;
    reg_we     = 1'b0;

    // STOP and START override every state.
    // A partial byte is discarded because writes only happen on the 8th rise.
    if (stop_det) begin
      state_d  = S_IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_WAIT_STOP: ;

        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d  = shift_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = '0;
              if (state_q == S_ADDR) begin
                if (shift_in[7:1] == SLAVE_ADDR) begin
                  rw_d    = shift_in[0];
                  state_d = S_ACK_ADDR;
                end else begin
                  state_d = S_WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_PTR) begin
                ptr_d   = shift_in[2:0];
                state_d = S_ACK_PTR;
              end else begin
                reg_we     = 1'b1;
                wr_pulse_d = 1'b1;
                wr_index_d = ptr_q;
                ptr_d      = ptr_q + 3'd1;
                state_d    = S_ACK_W;
              end
            end
          end
        end

        // bitcnt = 0: waiting for the fall after the 8th bit (start of ACK).
        // bitcnt = 1: ACK is driven, and the next fall ends it.
        S_ACK_ADDR, S_ACK_PTR, S_ACK_W: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
              bitcnt_d = 4'd1;
              if (state_q == S_ACK_ADDR) busy_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
              if (state_q == S_ACK_ADDR && rw_q) begin
                // The fall that ends the ACK also presents the first read bit.
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
                state_d  = S_RDATA;
              end else if (state_q == S_ACK_ADDR) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end

        // bitcnt counts master sampling rises.
        // Each fall presents the next bit, and the fall after the 8th rise releases SDA.
        S_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 3'd1;
              bitcnt_d = '0;
              state_d  = S_RACK;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end

        S_RACK: begin
          if (scl_rise) begin
            if (!sda_s_q) begin
              bitcnt_d = 4'd1;
            end else begin
              state_d = S_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && bitcnt_q == 4'd1) begin
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            bitcnt_d = '0;
            state_d  = S_RDATA;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
